// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the data RAM between the CPU MEM stage and a debug/loader port.
// Optional DRAM_ARB_STATS_EN adds a saturating CPU stall-cycle counter (stall_count, stats_clr).
module dram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
`ifdef DRAM_ARB_STATS_EN
  ,
  input  logic          stats_clr,
  output logic [15:0]   stall_count
`endif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  logic [0:0] state;
  logic [3:0] wait_cnt;
  logic force_dbg;
  always_comb begin
    force_dbg = dbg_req && wait_cnt == 4'(MAX_WAIT);
    cpu_gnt = reset && state == IDLE && cpu_req && !force_dbg;
    dbg_gnt = reset && dbg_req && (state == LOCK || force_dbg || !cpu_req);
    cpu_stall = cpu_req && !cpu_gnt;
    ram_we = cpu_gnt ? cpu_we : dbg_gnt && dbg_we;
    ram_addr = cpu_gnt ? cpu_addr : dbg_gnt ? dbg_addr : '0;
    ram_wdata = cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : '0;
  end
  // LOCK is held exactly while each granted debug access asks to keep ownership
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= (dbg_gnt && dbg_lock) ? LOCK : IDLE;
      wait_cnt <= (dbg_req && !dbg_gnt && state == IDLE)
                  ? (wait_cnt == 4'(MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1) : '0;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dbg_rvalid <= dbg_gnt && !dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= ram_rdata;
      if (dbg_gnt && !dbg_we) dbg_rdata <= ram_rdata;
    end
  end
`ifdef DRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset || stats_clr) stall_count <= '0;
    else if (cpu_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
`endif
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU MEM stage (EX/MEM register outputs) and a debug/loader port (program/data preload, register-dump readback).
- Sits between the EX/MEM pipeline register and the data RAM.
- Returns `cpu_stall` so pipeline control can freeze the PC, IF/ID and ID/EX while the MEM stage is denied.
- CPU has fixed priority. A starvation counter forces a debug grant after a bounded wait. A lock lets the debug port hold the RAM for back-to-back bursts.

Parameters:
- AW, 8, address width
- DW, 8, data width
- MAX_WAIT, 4, consecutive denied debug-request cycles before a forced debug grant (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU MEM-stage access request
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  one-cycle pulse, read data valid
- cpu_rdata  out  DW  registered read data
- dbg_req  in  1  debug access request
- dbg_we  in  1  1=write, 0=read
- dbg_lock  in  1  keep ownership after this access
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rvalid  out  1  one-cycle pulse, read data valid
- dbg_rdata  out  DW  registered read data
- ram_we  out  1  to data RAM write enable
- ram_addr  out  AW  to data RAM address
- ram_wdata  out  DW  to data RAM write data
- ram_rdata  in  DW  from data RAM, combinational read of ram_addr

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, wait_cnt=0.
  - cpu_rvalid, dbg_rvalid, cpu_rdata and dbg_rdata all 0.
  - Grants are forced to 0 while reset=0, so ram_we=0.
  - A pending rvalid is dropped, and an active lock is dropped.
- Grants are combinational from the registered state, wait_cnt and the current requests. At most one grant per cycle.
- State IDLE:
  - Force condition: dbg_req & (wait_cnt==MAX_WAIT).
  - If the force condition holds: dbg_gnt=1, cpu_gnt=0.
  - Else if cpu_req: cpu_gnt=1.
  - Else if dbg_req: dbg_gnt=1.
  - If dbg_gnt & dbg_lock: next state is LOCK.
- State LOCK:
  - dbg_gnt=dbg_req, cpu_gnt=0.
  - Next state is IDLE when dbg_req=0, or when dbg_gnt & ~dbg_lock. The final unlocked access is still performed.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when dbg_req & ~dbg_gnt.
  - Clears to 0 when dbg_gnt or ~dbg_req.
  - Not counted in LOCK.
- RAM mux:
  - ram_addr and ram_wdata are taken from the granted port; ram_we = granted port's we.
  - No grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Read return:
  - A granted read (we=0) captures ram_rdata into that port's rdata at the edge ending the grant cycle.
  - The port's rvalid is 1 for exactly the next cycle.
  - Latency: grant cycle N → rvalid in cycle N+1.
  - Back-to-back reads give continuous rvalid.
- Writes: the write is committed by the RAM at the edge ending the grant cycle; no rvalid is produced.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM write then read).
- rdata holds its last captured value until the next granted read for that port.
- A request without a grant must be held by the requester with stable fields; the arbiter has no queue.
- cpu_stall=1 while the CPU is denied (forced debug or LOCK); cpu_stall=0 when cpu_req=0.

Optional Feature:
- Macro: DRAM_ARB_STATS_EN.
- Defined:
  - Extra output port `stall_count`, 16 bits: counts cycles with cpu_stall=1.
  - Saturates at 0xFFFF. Cleared by reset.
  - Extra input `stats_clr`, 1 bit: synchronous clear. Clear wins over increment in the same cycle.
- Not defined: neither port exists and no counter logic is built. Arbitration is identical in both builds.

Test Plan:
- CPU read only: RAM[0x10]=0x5A, cpu_req=1, cpu_we=0, addr 0x10 → cpu_gnt=1 same cycle; cpu_rvalid=1 and cpu_rdata=0x5A next cycle; dbg_gnt=0 throughout.
- Contention, MAX_WAIT=4: cpu_req and dbg_req high continuously →
  - cpu_gnt cycles 0-3;
  - cycle 4: dbg_gnt=1, cpu_stall=1, wait_cnt→0;
  - pattern repeats with period 5.
- Locked burst: dbg writes 0x11,0x22,0x33 to 0x20-0x22 with dbg_lock=1,1,0 while cpu_req=1 →
  - ram_we=1 for 3 cycles, cpu_stall=1 for 3 cycles;
  - cpu_gnt in the 4th cycle;
  - CPU readback of 0x21 returns 0x22.
- Reset mid-operation: enter LOCK and issue a debug read, then reset=0 in the cycle before rvalid →
  - dbg_rvalid stays 0, all outputs 0;
  - after reset=1 with cpu_req=1: cpu_gnt immediately, state IDLE.
- Idle bus: no requests for 10 cycles → ram_we=0, ram_addr=0, no rvalid, wait_cnt stays 0.
- DRAM_ARB_STATS_EN build: repeat the contention test for 20 cycles → stall_count=4; stats_clr pulse → 0 next cycle.
